dmem_mmio_responder: RTL

- Responder on the data-memory bus driven by the pipelined core (address_dmem / data / wren / q_dmem).
- Claims a small word-addressed MMIO window and returns read data with the same one-cycle synchronous latency as the data RAM.
- Inside the window it provides a TX byte FIFO with a valid/ready drain port, a single-entry RX holding register, and a loadable free-running cycle counter.
- The wrapper muxes mmio_q onto q_dmem whenever mmio_hit_q is high.

---
 rtl/mmio_pkg.sv | 20 ++
 rtl/mmio_tx_fifo.sv | 72 +++++++
 rtl/dmem_mmio_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the data-memory MMIO responder: window base,
// register offsets and STATUS bit positions.
package mmio_pkg;

  // Word address of register offset 0. The window spans four words.
  localparam logic [31:0] MMIO_BASE = 32'h0000_1000;

  // Register offsets within the window (address_dmem[1:0]).
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_RXDATA = 2'd2;
  localparam logic [1:0] OFF_CYCLE  = 2'd3;

  // STATUS register bit positions.
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_RX_FULL  = 4;
  localparam int STAT_OVERFLOW = 5;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte-wide circular TX FIFO. Push/pop requests are qualified here so the
// caller only has to present intent; a push into a full FIFO is accepted
// when a pop frees a slot in the same cycle, otherwise it is dropped and
// reported through push_drop.
module mmio_tx_fifo #(
  parameter int TX_DEPTH = 8,
  parameter int TX_PTR_W = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop_req,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       push_drop
);

  logic [TX_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TX_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TX_PTR_W:0]   count_q, count_d;
  logic [7:0]          mem_q [TX_DEPTH];
  logic [7:0]          mem_d [TX_DEPTH];
  logic                pop_ok;
  logic                push_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (TX_PTR_W+1)'(TX_DEPTH));
  assign pop_ok    = pop_req && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign push_drop = push && full && !pop_ok;
  assign head      = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + TX_PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + TX_PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (TX_PTR_W+1)'(1);
      2'b01:   count_d = count_q - (TX_PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage is cleared so the head reads 0 out of reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < TX_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// MMIO responder on the data-memory bus. Decodes a four-word window and
// returns read data one cycle later, matching the data RAM latency. Holds
// the TX FIFO, the single-entry RX register, a sticky overflow flag and a
// loadable free-running cycle counter.
module dmem_mmio_responder #(
  parameter logic [31:0] MMIO_BASE = mmio_pkg::MMIO_BASE,
  parameter int          TX_DEPTH  = 8,
  parameter int          TX_PTR_W  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  input  logic        req_valid,
  output logic [31:0] mmio_q,
  output logic        mmio_hit_q,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid_in,
  input  logic [7:0]  rx_data_in,
  output logic        rx_ready
);

  import mmio_pkg::*;

  logic        hit;
  logic [1:0]  offset;
  logic        act;
  logic        tx_push;
  logic        tx_empty;
  logic        tx_full;
  logic        tx_drop;
  logic        rx_pop;
  logic        rx_drop;
  logic        ovf_clr;
  logic        cyc_load;
  logic [31:0] rd_val;

  logic [31:0] mmio_d;
  logic        mmio_hit_d;
  logic        rx_full_q, rx_full_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        overflow_q, overflow_d;
  logic [31:0] cycle_q, cycle_d;

  assign hit    = (address_dmem[31:2] == MMIO_BASE[31:2]);
  assign offset = address_dmem[1:0];
  assign act    = hit && req_valid;

  assign tx_push  = act && wren && (offset == OFF_TXDATA);
  assign rx_pop   = act && !wren && (offset == OFF_RXDATA) && rx_full_q;
  assign ovf_clr  = act && wren && (offset == OFF_STATUS) && data[STAT_OVERFLOW];
  assign cyc_load = act && wren && (offset == OFF_CYCLE);
  // rx_ready is low whenever the register is full, so an incoming byte is
  // dropped even if the CPU pops in the same cycle.
  assign rx_drop  = rx_valid_in && rx_full_q;

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full_q;

  mmio_tx_fifo #(
    .TX_DEPTH (TX_DEPTH),
    .TX_PTR_W (TX_PTR_W)
  ) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (data[7:0]),
    .pop_req   (tx_ready),
    .head      (tx_data),
    .empty     (tx_empty),
    .full      (tx_full),
    .push_drop (tx_drop)
  );

  // Read mux from current register state; outside the window it returns 0.
  always_comb begin
    rd_val = '0;
    case (offset)
      OFF_TXDATA: rd_val = '0;
      OFF_STATUS: begin
        rd_val[STAT_TX_EMPTY] = tx_empty;
        rd_val[STAT_TX_FULL]  = tx_full;
        rd_val[STAT_RX_FULL]  = rx_full_q;
        rd_val[STAT_OVERFLOW] = overflow_q;
      end
      OFF_RXDATA: rd_val = rx_full_q ? {24'b0, rx_byte_q} : 32'b0;
      default:    rd_val = cycle_q;
    endcase
    mmio_d     = hit ? rd_val : 32'b0;
    mmio_hit_d = hit;
  end

  // RX holding register, sticky overflow and cycle counter next-state.
  always_comb begin
    rx_full_d  = rx_full_q;
    rx_byte_d  = rx_byte_q;
    overflow_d = overflow_q;
    cycle_d    = cycle_q + 32'd1;

    if (rx_pop) begin
      rx_full_d = 1'b0;
    end else if (rx_valid_in && !rx_full_q) begin
      rx_full_d = 1'b1;
      rx_byte_d = rx_data_in;
    end

    // A fresh overflow event outranks a clear in the same cycle so it is
    // never silently lost.
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    if (tx_drop || rx_drop) begin
      overflow_d = 1'b1;
    end

    if (cyc_load) begin
      cycle_d = data;
    end
  end

  // Register all responder state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mmio_q     <= '0;
      mmio_hit_q <= 1'b0;
      rx_full_q  <= 1'b0;
      rx_byte_q  <= '0;
      overflow_q <= 1'b0;
      cycle_q    <= '0;
    end else begin
      mmio_q     <= mmio_d;
      mmio_hit_q <= mmio_hit_d;
      rx_full_q  <= rx_full_d;
      rx_byte_q  <= rx_byte_d;
      overflow_q <= overflow_d;
      cycle_q    <= cycle_d;
    end
  end

endmodule
